// File: rtl/countdown_timer.sv
// Countdown timer: selects an interval from the parameter store, loads its seconds value and
// counts it down with a prescaler. Optional LED blink on status_blink via macro TIMER_BLINK_EN.
module countdown_timer #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_req,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       status_blink,
  output logic [1:0] state_dbg
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    WAIT  = 2'd2,
    COUNT = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          load_sel;
  logic          load_val;
  logic          restart;
  logic          fire;
  logic          dec;

  assign state_dbg = state;
  assign tick      = (prescaler == PRE_LAST);

  // start_timer is a level with no ready: it is taken on any edge in IDLE, WAIT or COUNT
  // (never in SEL), and a take outside IDLE aborts the current run without an expired pulse.
  always_comb begin
    state_next = state;
    load_sel   = 1'b0;
    load_val   = 1'b0;
    restart    = 1'b0;
    fire       = 1'b0;
    dec        = 1'b0;
    case (state)
      IDLE: begin
        if (start_timer) begin
          load_sel   = 1'b1;
          state_next = SEL;
        end
      end
      SEL: state_next = WAIT;
      WAIT: begin
        if (start_timer) begin
          load_sel   = 1'b1;
          restart    = 1'b1;
          state_next = SEL;
        end else begin
          load_val   = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (start_timer) begin
          load_sel   = 1'b1;
          restart    = 1'b1;
          state_next = SEL;
        end else if (remaining == 4'd0) begin
          // only reachable when a zero value was loaded: expire without a prescaler wait
          fire       = 1'b1;
          state_next = IDLE;
        end else if (tick) begin
          if (remaining == 4'd1) begin
            fire       = 1'b1;
            state_next = IDLE;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      interval  <= 2'd0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      remaining <= 4'd0;
      prescaler <= '0;
    end else begin
      state   <= state_next;
      expired <= fire;
      if (load_sel) interval <= interval_req;
      if (load_sel)  busy <= 1'b1;
      else if (fire) busy <= 1'b0;
      if (load_val)               remaining <= value;
      else if (restart || fire)   remaining <= 4'd0;
      else if (dec)               remaining <= remaining - 4'd1;
      if (state == COUNT && state_next == COUNT) prescaler <= tick ? '0 : prescaler + 1'b1;
      else                                       prescaler <= '0;
    end
  end

`ifdef TIMER_BLINK_EN
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_CYCLES / 2 - 1);
  logic blink_q;

  // toggles twice per second while counting; cleared on leaving COUNT, including expiry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else if (state == COUNT && state_next == COUNT) begin
      if (prescaler == PRE_HALF || tick) blink_q <= ~blink_q;
    end else begin
      blink_q <= 1'b0;
    end
  end

  assign status_blink = blink_q;
`else
  assign status_blink = busy;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_CYCLES=4) with a one-edge-latency parameter store model
// and an expected-expiry-cycle scoreboard.
module tb_countdown_timer;
  localparam int TICK = 4;
  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_SEL   = 32'd1;
  localparam logic [31:0] ST_COUNT = 32'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] interval_req = 2'd0;
  logic [3:0] value = 4'd0;
  logic [1:0] interval;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;
  logic       status_blink;
  logic [1:0] state_dbg;

  logic [3:0]  store_tbl [4];
  logic [31:0] exp_q [$];
  logic [31:0] cyc = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  countdown_timer #(.TICK_CYCLES(TICK)) dut (
    .clock(clock), .reset(reset), .start_timer(start_timer), .interval_req(interval_req),
    .value(value), .interval(interval), .expired(expired), .busy(busy),
    .remaining(remaining), .status_blink(status_blink), .state_dbg(state_dbg)
  );

  // clock / reset-free cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 32'd1;

  // parameter store: value follows interval one edge later
  always @(posedge clock) value <= store_tbl[interval];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every expired pulse must match the oldest expected expiry cycle
  always @(negedge clock) begin
    logic [31:0] e;
    if (expired) begin
      if (exp_q.size() == 0) begin
        check("expired_unexpected", 32'(expired), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("expired_cycle", cyc, e);
      end
    end
`ifdef TIMER_BLINK_EN
    if (!busy) check("blink_idle", 32'(status_blink), 32'd0);
`else
    check("blink_busy", 32'(status_blink), 32'(busy));
`endif
  end

  task automatic wait_negs(input int n);
    repeat (n) @(negedge clock);
  endtask

  // one-cycle start pulse; returns at the negedge after E0 with the expiry queued
  task automatic start_run(input logic [1:0] req, input logic [3:0] v);
    store_tbl[req] = v;
    interval_req   = req;
    start_timer    = 1'b1;
    exp_q.push_back(cyc + 32'd3 + ((v == 4'd0) ? 32'd1 : 32'(v) * TICK));
    @(negedge clock);
    start_timer  = 1'b0;
    interval_req = 2'($urandom_range(0, 3));
  endtask

  task automatic abort_run();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clock);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) store_tbl[i] = 4'd0;
    wait_negs(3);
    check("rst_state", 32'(state_dbg), ST_IDLE);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_interval", 32'(interval), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    check("rst_blink", 32'(status_blink), 32'd0);
    reset = 1'b0;
    wait_negs(2);

    // 1: value 6, expiry 24 cycles after load; store changes during COUNT are ignored
    start_run(2'd0, 4'd6);
    check("t1_interval", 32'(interval), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state_sel", 32'(state_dbg), ST_SEL);
    wait_negs(2);
    check("t1_remaining_load", 32'(remaining), 32'd6);
    check("t1_state_count", 32'(state_dbg), ST_COUNT);
    store_tbl[0] = 4'd15;
    wait_negs(TICK);
    check("t1_remaining_tick", 32'(remaining), 32'd5);
    wait_idle(40);
    check("t1_remaining_end", 32'(remaining), 32'd0);
    wait_negs(2);

    // 2: zero value expires one edge after the load
    start_run(2'd3, 4'd0);
    check("t2_interval", 32'(interval), 32'd3);
    wait_negs(2);
    check("t2_remaining", 32'(remaining), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_negs(1);
    check("t2_expired", 32'(expired), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    wait_negs(2);

    // 3: restart at E2+6 aborts a 3 s run and reloads 8
    start_run(2'd2, 4'd3);
    wait_negs(2 + 5);
    abort_run();
    start_run(2'd1, 4'd8);
    check("t3_busy_restart", 32'(busy), 32'd1);
    wait_negs(2);
    check("t3_remaining", 32'(remaining), 32'd8);
    check("t3_interval", 32'(interval), 32'd1);
    wait_idle(50);
    wait_negs(2);

    // 4: asynchronous reset mid-count
    start_run(2'd2, 4'd2);
    wait_negs(2 + 4);
    abort_run();
    reset = 1'b1;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_remaining", 32'(remaining), 32'd0);
    check("t4_interval", 32'(interval), 32'd0);
    check("t4_state", 32'(state_dbg), ST_IDLE);
    check("t4_blink", 32'(status_blink), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_negs(1);
    start_run(2'd0, 4'd2);
    wait_negs(2);
    check("t4_remaining_after", 32'(remaining), 32'd2);
    wait_idle(30);
    wait_negs(2);

    // 5: start on the tick-to-zero edge wins over expiry
    start_run(2'd1, 4'd1);
    wait_negs(2 + 3);
    abort_run();
    start_run(2'd1, 4'd1);
    check("t5_state", 32'(state_dbg), ST_SEL);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_expired", 32'(expired), 32'd0);
    wait_idle(30);
    wait_negs(2);

    // held start keeps retriggering; dropped before E0+10 it loads at E0+10
    store_tbl[3]  = 4'd1;
    interval_req  = 2'd3;
    start_timer   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("held_busy", 32'(busy), 32'd1);
    end
    start_timer = 1'b0;
    exp_q.push_back(cyc + 32'd1 + 32'd4 * TICK / 4);
    wait_idle(30);
    wait_negs(2);

`ifdef TIMER_BLINK_EN
    // 6: blink sequence for a 2 s run, sampled after edges E2+1..E2+8
    begin
      logic blink_exp [8];
      blink_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      start_run(2'd0, 4'd2);
      wait_negs(2);
      check("t6_blink_load", 32'(status_blink), 32'd0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        check("t6_blink_seq", 32'(status_blink), 32'(blink_exp[k]));
      end
      wait_idle(10);
    end
`else
    start_run(2'd0, 4'd2);
    wait_idle(20);
`endif
    wait_negs(3);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
